// File: rtl/battle_sequencer_pkg.sv
// Shared types and constants for the battle-screen turn/phase sequencer.
// Optional VICTORY_EN adds the VICTORY state encoding.
package battle_pkg;

`ifdef VICTORY_EN
   typedef enum logic [2:0] {
      ST_PLAY,
      ST_OVER_IDLE,
      ST_OVER_BREAK,
      ST_OVER_SHATTER,
      ST_OVER_FADE,
      ST_VICTORY
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_PLAY,
      ST_OVER_IDLE,
      ST_OVER_BREAK,
      ST_OVER_SHATTER,
      ST_OVER_FADE
   } state_t;
`endif

   localparam logic [1:0] ANIM_IDLE    = 2'd0;
   localparam logic [1:0] ANIM_BREAK   = 2'd1;
   localparam logic [1:0] ANIM_SHATTER = 2'd2;
   localparam logic [1:0] ANIM_FADE    = 2'd3;

   localparam int NIBBLE_W = 4;
   localparam int COLOR_W  = 3 * NIBBLE_W;

   function automatic logic [NIBBLE_W-1:0] sat_inc(input logic [NIBBLE_W-1:0] nib);
      return (nib == '1) ? nib : nib + NIBBLE_W'(1);
   endfunction

endpackage

// File: rtl/battle_sequencer_if.sv
// Battle-sequencer signal bundle: raster position, phase-engine levels in, selects/strobes out.
// master = sequencer side, slave = caller side; no handshake, all levels/pulses.
interface battle_sequencer_if #(
   parameter int NUM_PHASES = 3,
   parameter int NUM_TURNS  = 10
);
   localparam int PH_W = $clog2(NUM_PHASES);
   localparam int TU_W = $clog2(NUM_TURNS + 1);

   logic [10:0]           hcount_in;
   logic [9:0]            vcount_in;
   logic [NUM_PHASES-1:0] finish_in;
   logic                  game_over_in;
   logic                  win_in;
   logic [PH_W-1:0]       phase_out;
   logic [TU_W-1:0]       turn_out;
   logic                  round_rst_out;
   logic                  over_out;
   logic [1:0]            anim_phase_out;
   logic                  divided_out;
   logic                  fall_apart_valid_out;
   logic [11:0]           font_color_out;
   logic                  victory_out;

   modport master (
      input  hcount_in, vcount_in, finish_in, game_over_in, win_in,
      output phase_out, turn_out, round_rst_out, over_out, anim_phase_out,
             divided_out, fall_apart_valid_out, font_color_out, victory_out
   );

   modport slave (
      output hcount_in, vcount_in, finish_in, game_over_in, win_in,
      input  phase_out, turn_out, round_rst_out, over_out, anim_phase_out,
             divided_out, fall_apart_valid_out, font_color_out, victory_out
   );
endinterface

// File: rtl/battle_sequencer_fade_ramp.sv
// Text fade: counts frame strobes while enabled, every FADE_FRAMES-th bumps masked nibbles (saturating).
// Colour updates on the clock edge that samples the qualifying strobe; no backpressure.
module fade_ramp
   import battle_pkg::*;
#(
   parameter int         FADE_FRAMES = 8,
   parameter logic [2:0] MASK        = 3'b111
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_en,
   input  logic               i_strobe,
   output logic [COLOR_W-1:0] o_color
);
   localparam int FR_W = $clog2(FADE_FRAMES + 1);
   localparam logic [FR_W-1:0] FR_LAST = FR_W'(FADE_FRAMES - 1);

   logic [FR_W-1:0]    r_frame;
   logic [COLOR_W-1:0] r_color;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame <= '0;
         r_color <= '0;
      end else if (i_en && i_strobe) begin
         if (r_frame == FR_LAST) begin
            r_frame <= '0;
            for (int i = 0; i < 3; i++) begin
               if (MASK[i])
                  r_color[i*NIBBLE_W +: NIBBLE_W] <= sat_inc(r_color[i*NIBBLE_W +: NIBBLE_W]);
            end
         end else begin
            r_frame <= r_frame + FR_W'(1);
         end
      end
   end

   assign o_color = r_color;
endmodule

// File: rtl/battle_sequencer.sv
// Battle-screen turn/phase controller plus timed game-over animation; optional VICTORY_EN state.
// All outputs registered, one-cycle response to input rises; no backpressure.
module battle_sequencer
   import battle_pkg::*;
#(
   parameter int NUM_PHASES     = 3,
   parameter int NUM_TURNS      = 10,
   parameter int IDLE_CYCLES    = 65000000,
   parameter int BREAK_CYCLES   = 130000000,
   parameter int SHATTER_CYCLES = 130000000,
   parameter int FADE_FRAMES    = 8,
   parameter int COUNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   battle_sequencer_if.master bus
);
   localparam int PH_W = $clog2(NUM_PHASES);
   localparam int TU_W = $clog2(NUM_TURNS + 1);
   localparam logic [PH_W-1:0]    PH_LAST      = PH_W'(NUM_PHASES - 1);
   localparam logic [TU_W-1:0]    TU_LAST      = TU_W'(NUM_TURNS - 1);
   localparam logic [COUNT_W-1:0] IDLE_LAST    = COUNT_W'(IDLE_CYCLES - 1);
   localparam logic [COUNT_W-1:0] BREAK_LAST   = COUNT_W'(BREAK_CYCLES - 1);
   localparam logic [COUNT_W-1:0] SHATTER_LAST = COUNT_W'(SHATTER_CYCLES - 1);

   state_t                r_state;
   logic [COUNT_W-1:0]    r_timer;
   logic [NUM_PHASES-1:0] r_finish_q;
   logic                  r_go_q;
   logic [PH_W-1:0]       r_phase;
   logic [TU_W-1:0]       r_turn;
   logic                  r_round_rst;
   logic                  r_over;
   logic [1:0]            r_anim;
   logic                  r_divided;
   logic                  r_fall;
   logic                  r_victory;

   logic [NUM_PHASES-1:0] w_fin_rise;
   logic                  w_go_rise;
   logic                  w_strobe;
   logic [COLOR_W-1:0]    w_over_color;

   assign w_fin_rise = bus.finish_in & ~r_finish_q;
   assign w_go_rise  = bus.game_over_in & ~r_go_q;
   assign w_strobe   = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);

`ifdef VICTORY_EN
   logic               r_win_q;
   logic               w_win_rise;
   logic [COLOR_W-1:0] w_vic_color;

   assign w_win_rise = bus.win_in & ~r_win_q;

   always_ff @(posedge clk) begin
      if (rst) r_win_q <= 1'b0;
      else     r_win_q <= bus.win_in;
   end

   fade_ramp #(.FADE_FRAMES(FADE_FRAMES), .MASK(3'b010)) u_vic_ramp (
      .clk(clk), .rst(rst), .i_en(r_state == ST_VICTORY), .i_strobe(w_strobe), .o_color(w_vic_color)
   );
   // Only one ramp is ever enabled, the other stays at zero.
   assign bus.font_color_out = w_over_color | w_vic_color;
`else
   assign bus.font_color_out = w_over_color;
`endif

   fade_ramp #(.FADE_FRAMES(FADE_FRAMES), .MASK(3'b111)) u_over_ramp (
      .clk(clk), .rst(rst), .i_en(r_state == ST_OVER_FADE), .i_strobe(w_strobe), .o_color(w_over_color)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_PLAY;
         r_timer     <= '0;
         r_finish_q  <= '0;
         r_go_q      <= 1'b0;
         r_phase     <= '0;
         r_turn      <= '0;
         r_round_rst <= 1'b0;
         r_over      <= 1'b0;
         r_anim      <= ANIM_IDLE;
         r_divided   <= 1'b0;
         r_fall      <= 1'b0;
         r_victory   <= 1'b0;
      end else begin
         r_finish_q  <= bus.finish_in;
         r_go_q      <= bus.game_over_in;
         r_round_rst <= 1'b0;
         case (r_state)
            ST_PLAY: begin
               if (w_go_rise) begin
                  r_state <= ST_OVER_IDLE;
                  r_timer <= '0;
                  r_over  <= 1'b1;
                  r_anim  <= ANIM_IDLE;
               end
`ifdef VICTORY_EN
               else if (w_win_rise) begin
                  r_state   <= ST_VICTORY;
                  r_victory <= 1'b1;
                  r_anim    <= ANIM_FADE;
               end
`endif
               // The round-reset cycle lets phase engines clear before any new finish counts.
               else if (!r_round_rst && w_fin_rise[r_phase]) begin
                  if (r_phase != PH_LAST) begin
                     r_phase <= r_phase + PH_W'(1);
                  end else begin
                     r_phase     <= '0;
                     r_turn      <= (r_turn == TU_LAST) ? '0 : r_turn + TU_W'(1);
                     r_round_rst <= 1'b1;
                  end
               end
            end
            ST_OVER_IDLE: begin
               if (r_timer == IDLE_LAST) begin
                  r_state   <= ST_OVER_BREAK;
                  r_timer   <= '0;
                  r_anim    <= ANIM_BREAK;
                  r_divided <= 1'b1;
               end else begin
                  r_timer <= r_timer + COUNT_W'(1);
               end
            end
            ST_OVER_BREAK: begin
               if (r_timer == BREAK_LAST) begin
                  r_state <= ST_OVER_SHATTER;
                  r_timer <= '0;
                  r_anim  <= ANIM_SHATTER;
                  r_fall  <= 1'b1;
               end else begin
                  r_timer <= r_timer + COUNT_W'(1);
               end
            end
            ST_OVER_SHATTER: begin
               if (r_timer == SHATTER_LAST) begin
                  r_state   <= ST_OVER_FADE;
                  r_timer   <= '0;
                  r_anim    <= ANIM_FADE;
                  r_fall    <= 1'b0;
                  r_divided <= 1'b0;
               end else begin
                  r_timer <= r_timer + COUNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.phase_out            = r_phase;
   assign bus.turn_out             = r_turn;
   assign bus.round_rst_out        = r_round_rst;
   assign bus.over_out             = r_over;
   assign bus.anim_phase_out       = r_anim;
   assign bus.divided_out          = r_divided;
   assign bus.fall_apart_valid_out = r_fall;
   assign bus.victory_out          = r_victory;
endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer: phases/turns, game-over timing, fade ramp, reset, VICTORY_EN.
module tb_battle_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   int   nst      = 0;

   always #5 clk = ~clk;

   battle_sequencer_if #(.NUM_PHASES(3), .NUM_TURNS(3)) bus ();

   battle_sequencer #(
      .NUM_PHASES(3), .NUM_TURNS(3), .IDLE_CYCLES(4), .BREAK_CYCLES(5),
      .SHATTER_CYCLES(6), .FADE_FRAMES(2), .COUNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_phase"}, 32'(bus.phase_out), 0);
      check({tag, "_turn"}, 32'(bus.turn_out), 0);
      check({tag, "_rrst"}, 32'(bus.round_rst_out), 0);
      check({tag, "_over"}, 32'(bus.over_out), 0);
      check({tag, "_anim"}, 32'(bus.anim_phase_out), 0);
      check({tag, "_div"}, 32'(bus.divided_out), 0);
      check({tag, "_fall"}, 32'(bus.fall_apart_valid_out), 0);
      check({tag, "_font"}, 32'(bus.font_color_out), 0);
      check({tag, "_vic"}, 32'(bus.victory_out), 0);
   endtask

   task automatic rise(input int idx);
      bus.finish_in = 3'b000;
      bus.finish_in[idx] = 1'b1;
      tick();
   endtask

   task automatic release_fin();
      bus.finish_in = 3'b000;
      tick();
   endtask

   task automatic strobe();
      bus.hcount_in = 11'd0;
      bus.vcount_in = 10'd0;
      tick();
      bus.hcount_in = 11'd5;
      bus.vcount_in = 10'd3;
      tick();
      nst++;
   endtask

   function automatic logic [31:0] exp_col(input int n, input logic [2:0] mask);
      logic [3:0] s;
      s = (n / 2 > 15) ? 4'hF : 4'(n / 2);
      return {20'd0, mask[2] ? s : 4'h0, mask[1] ? s : 4'h0, mask[0] ? s : 4'h0};
   endfunction

   initial begin
      rst = 1'b1;
      bus.hcount_in = 11'd5;
      bus.vcount_in = 10'd3;
      bus.finish_in = 3'b000;
      bus.game_over_in = 1'b0;
      bus.win_in = 1'b0;
      tick();
      tick();
      check_zero("reset");
      rst = 1'b0;
      tick();

      // Single round: 0->1->2->0, turn 0->1, one-cycle round reset
      rise(0); check("t1_ph1", 32'(bus.phase_out), 1); release_fin();
      rise(1); check("t1_ph2", 32'(bus.phase_out), 2); release_fin();
      rise(2);
      check("t1_ph0", 32'(bus.phase_out), 0);
      check("t1_turn", 32'(bus.turn_out), 1);
      check("t1_rrst_hi", 32'(bus.round_rst_out), 1);
      release_fin();
      check("t1_rrst_lo", 32'(bus.round_rst_out), 0);

      // Two more rounds: turn 2, then wraps to 0
      rise(0); release_fin(); rise(1); release_fin(); rise(2); release_fin();
      check("t2_turn2", 32'(bus.turn_out), 2);
      rise(0); release_fin(); rise(1); release_fin(); rise(2); release_fin();
      check("t2_wrap", 32'(bus.turn_out), 0);
      rise(2);
      check("t2_wrongbit_ph", 32'(bus.phase_out), 0);
      check("t2_wrongbit_turn", 32'(bus.turn_out), 0);
      release_fin();

      // A finish rise landing in the round-reset cycle is swallowed
      rise(0); release_fin(); rise(1); release_fin();
      bus.finish_in = 3'b100; tick();
      check("t2_rr_pulse", 32'(bus.round_rst_out), 1);
      check("t2_rr_turn", 32'(bus.turn_out), 1);
      bus.finish_in = 3'b101; tick();
      check("t2_rr_noadv", 32'(bus.phase_out), 0);
      tick();
      check("t2_rr_held", 32'(bus.phase_out), 0);
      release_fin();

      // Game over beats a simultaneous finish rise; animation timing
      rise(0); release_fin();
      check("t3_pre_ph", 32'(bus.phase_out), 1);
      bus.game_over_in = 1'b1;
      bus.finish_in = 3'b010;
      tick();
      check("t3_over", 32'(bus.over_out), 1);
      check("t3_ph_hold", 32'(bus.phase_out), 1);
      check("t3_turn_hold", 32'(bus.turn_out), 1);
      bus.game_over_in = 1'b0;
      bus.finish_in = 3'b000;
      for (int i = 1; i < 4; i++) begin
         if (i == 2) bus.finish_in = 3'b010;
         tick();
         check("t3_idle_anim", 32'(bus.anim_phase_out), 0);
      end
      bus.finish_in = 3'b000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_break_anim", 32'(bus.anim_phase_out), 1);
         check("t3_break_div", 32'(bus.divided_out), 1);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t3_shat_anim", 32'(bus.anim_phase_out), 2);
         check("t3_shat_fall", 32'(bus.fall_apart_valid_out), 1);
         check("t3_shat_div", 32'(bus.divided_out), 1);
      end
      tick();
      check("t3_fade_anim", 32'(bus.anim_phase_out), 3);
      check("t3_fade_fall", 32'(bus.fall_apart_valid_out), 0);
      check("t3_fade_ph", 32'(bus.phase_out), 1);
      check("t3_fade_font0", 32'(bus.font_color_out), 0);

      // Fade ramp: one step per two strobes, saturating at FFF
      for (int i = 0; i < 4; i++) begin
         strobe();
         check("t4_ramp", 32'(bus.font_color_out), exp_col(nst, 3'b111));
      end
      bus.hcount_in = 11'd5; bus.vcount_in = 10'd0; tick();
      bus.hcount_in = 11'd0; bus.vcount_in = 10'd3; tick();
      check("t4_nonstrobe", 32'(bus.font_color_out), 32'h222);
      bus.hcount_in = 11'd0; bus.vcount_in = 10'd0;
      tick(); tick(); tick();
      nst += 3;
      bus.hcount_in = 11'd5; bus.vcount_in = 10'd3;
      tick();
      check("t4_held3", 32'(bus.font_color_out), 32'h333);
      while (nst < 30) begin
         strobe();
         check("t4_ramp", 32'(bus.font_color_out), exp_col(nst, 3'b111));
      end
      check("t4_full", 32'(bus.font_color_out), 32'hFFF);
      strobe(); strobe();
      check("t4_sat", 32'(bus.font_color_out), 32'hFFF);
      check("t4_terminal", 32'(bus.anim_phase_out), 3);

      // Reset mid-shatter, then a fresh game over restarts at idle
      rst = 1'b1; tick(); rst = 1'b0;
      check_zero("t5_rst1");
      bus.game_over_in = 1'b1; tick();
      check("t5_go_over", 32'(bus.over_out), 1);
      bus.game_over_in = 1'b0;
      repeat (3) tick();
      check("t5_idle", 32'(bus.anim_phase_out), 0);
      repeat (5) tick();
      check("t5_break", 32'(bus.anim_phase_out), 1);
      repeat (2) tick();
      check("t5_shat", 32'(bus.anim_phase_out), 2);
      rst = 1'b1; tick(); rst = 1'b0;
      check_zero("t5_rst2");
      tick();
      bus.game_over_in = 1'b1; tick();
      check("t5_re_over", 32'(bus.over_out), 1);
      check("t5_re_anim", 32'(bus.anim_phase_out), 0);
      bus.game_over_in = 1'b0;
      repeat (3) tick();
      check("t5_re_idle", 32'(bus.anim_phase_out), 0);
      tick();
      check("t5_re_break", 32'(bus.anim_phase_out), 1);

      // Win rise
      rst = 1'b1; tick(); rst = 1'b0; tick();
      nst = 0;
      bus.win_in = 1'b1; tick();
`ifdef VICTORY_EN
      check("t6_vic", 32'(bus.victory_out), 1);
      check("t6_anim", 32'(bus.anim_phase_out), 3);
      check("t6_over", 32'(bus.over_out), 0);
      bus.win_in = 1'b0;
      strobe(); strobe();
      check("t6_g1", 32'(bus.font_color_out), 32'h010);
      while (nst < 30) strobe();
      check("t6_gfull", 32'(bus.font_color_out), 32'h0F0);
      strobe(); strobe();
      check("t6_gsat", 32'(bus.font_color_out), 32'h0F0);
`else
      check("t6_novic", 32'(bus.victory_out), 0);
      check("t6_noanim", 32'(bus.anim_phase_out), 0);
      bus.win_in = 1'b0;
      rise(0);
      check("t6_play_ok", 32'(bus.phase_out), 1);
      release_fin();
      strobe();
      check("t6_nofont", 32'(bus.font_color_out), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
